pe_inject_arbiter: RTL

//  Clocked round-robin arbiter sharing one NoC injection port among NUM_REQ processing-element packetizers.

---
 rtl/pe_arb_pkg.sv | 32 +++
 rtl/pe_inject_arbiter_rr_priority_picker.sv | 38 +++
 rtl/pe_inject_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the PE injection arbiter.
package pe_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_PKT_W   = 32;

    // Packet header field positions
    localparam int PKT_DEST_MSB = 31;
    localparam int PKT_DEST_LSB = 28;
    localparam int PKT_OPC_MSB  = 27;
    localparam int PKT_OPC_LSB  = 24;

    typedef logic [DEF_PKT_W-1:0]           pkt_t;
    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

    // The output register state. It is encoded directly by out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    // Extract the destination field of a packet
    function automatic logic [3:0] pkt_dest(input pkt_t p);
        return p[PKT_DEST_MSB:PKT_DEST_LSB];
    endfunction

    // Extract the opcode field of a packet
    function automatic logic [3:0] pkt_opcode(input pkt_t p);
        return p[PKT_OPC_MSB:PKT_OPC_LSB];
    endfunction

endpackage

// File: rtl/pe_inject_arbiter_rr_priority_picker.sv
// Round-robin priority picker. It is purely combinational. It returns the first
// requester at or after i_rr_ptr, wrapping modulo N.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int            w_j;
    logic [IW-1:0] w_sel;

    // Scan N positions starting at the pointer. The first requester found wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(i_rr_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_sel = IW'(w_j);
            if (!o_any && i_req[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/pe_inject_arbiter.sv
// Round-robin arbiter that shares one NoC injection port among NUM_REQ PE
// packetizers. A credit counter gates it; the counter mirrors the router input
// buffer.
//
// Handshake: a transfer happens on a posedge where valid & ready are both high.
// A source raises valid without looking at ready. It holds valid and its data
// stable until the transfer. Ready may depend on valid in the same cycle.
// Output data and output source stay stable while out_valid & !out_ready.
module pe_inject_arbiter
    import pe_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int PKT_W   = DEF_PKT_W,
    parameter  int CREDITS = 4,
    parameter  int CNT_W   = 16,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_data,
    output logic [IW-1:0]            out_src,
    input  logic                     out_ready,
    input  logic                     credit_ret,
    output logic [CW-1:0]            credit_cnt,
    output logic                     credit_err,
    output logic [CNT_W-1:0]         pkt_count,
    output arb_state_t               dbg_state,
    output logic [IW-1:0]            dbg_rr_ptr
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [PKT_W-1:0] r_out_data;
    logic [IW-1:0]    r_out_src;
    logic [IW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_credit_cnt;
    logic             r_credit_err;
    logic [CNT_W-1:0] r_pkt_count;

    logic               w_out_valid;
    logic               w_slot_free;
    logic               w_can_grant;
    logic [NUM_REQ-1:0] w_req_gated;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [IW-1:0]      w_win_idx;
    logic               w_grant;
    logic [PKT_W-1:0]   w_win_data;
    logic [IW-1:0]      w_rr_nxt;

    assign w_out_valid = (r_state == ST_FULL);
    assign w_slot_free = !w_out_valid || out_ready;
    // Grants are held off during reset, so the register never drops an accepted packet.
    assign w_can_grant = w_slot_free && (r_credit_cnt != '0) && !reset;
    assign w_req_gated = req_valid & {NUM_REQ{w_can_grant}};

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .i_req    (w_req_gated),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_grant)
    );

    assign w_win_data = req_data[w_win_idx*PKT_W +: PKT_W];
    assign w_rr_nxt   = (w_win_idx == IW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    // Next-state logic for the output register: a grant fills it, and a drain with no grant empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_grant) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload capture, pointer advance and packet telemetry on grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
            r_pkt_count <= '0;
        end else if (w_grant) begin
            r_out_data  <= w_win_data;
            r_out_src   <= w_win_idx;
            r_rr_ptr    <= w_rr_nxt;
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    // Credits: a grant consumes one credit and a return restores one. A return when the count is already full saturates and flags an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit_cnt <= CW'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            case ({w_grant, credit_ret})
                2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01: begin
                    if (r_credit_cnt == CW'(CREDITS)) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + 1'b1;
                    end
                end
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

    assign req_ready  = w_grant_oh;
    assign out_valid  = w_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign credit_cnt = r_credit_cnt;
    assign credit_err = r_credit_err;
    assign pkt_count  = r_pkt_count;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule
